// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with a two-state refill FSM.
// Optional hit/miss counters are compiled in with ICACHE_STATS_EN.
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic [31:0] imemload,
    output logic        ihit,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
`ifdef ICACHE_STATS_EN
    input  logic        iwait,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`else
    input  logic        iwait
`endif
);
    localparam int IDX = $clog2(SETS);
    localparam int TAG = 30 - IDX;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SETS-1:0]    valid_q;
    logic [TAG-1:0]     tag_q  [SETS];
    logic [31:0]        data_q [SETS];
    logic [29:0]        miss_q, miss_d;

    logic [IDX-1:0]     req_idx;
    logic [TAG-1:0]     req_tag;
    logic [IDX-1:0]     miss_idx;
    logic [TAG-1:0]     miss_tag;
    logic               hit;
    logic               fill;
    logic               start_miss;
    logic [1:0]         unused_offset;

    assign req_idx       = imemaddr[1+IDX:2];
    assign req_tag       = imemaddr[31:2+IDX];
    assign miss_idx      = miss_q[IDX-1:0];
    assign miss_tag      = miss_q[29:IDX];
    assign unused_offset = imemaddr[1:0];

    assign hit      = imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    assign imemload = data_q[req_idx];
    assign iaddr    = {miss_q, 2'b00};

    always_comb begin
        state_d    = state_q;
        miss_d     = miss_q;
        ihit       = 1'b0;
        iREN       = 1'b0;
        fill       = 1'b0;
        start_miss = 1'b0;
        case (state_q)
            IDLE: begin
                ihit = hit;
                if (imemREN && !hit) begin
                    miss_d     = imemaddr[31:2];
                    start_miss = 1'b1;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                iREN = 1'b1;
                // The memory transaction cannot be aborted, so the fill ignores imemREN.
                if (!iwait) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
            for (int i = 0; i < SETS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (fill) begin
            valid_q[miss_idx] <= 1'b1;
            tag_q[miss_idx]   <= miss_tag;
            data_q[miss_idx]  <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (ihit && hit_cnt_q != 32'hFFFF_FFFF)
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (start_miss && miss_cnt_q != 32'hFFFF_FFFF)
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    logic unused_start;
    assign unused_start = start_miss;
`endif

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache that answers the datapath's instruction-fetch requests and refills from memory on a miss. It sits between the pipeline's fetch stage (request: `imemREN`/`imemaddr`; response: `ihit`/`imemload`) and the memory controller's instruction port (`iREN`/`iaddr`/`iload`/`iwait`). It holds 16 one-word frames and runs a two-state refill FSM. An optional pair of hit/miss counters can be compiled in.

## Interface
Parameters:
- `SETS`, 16: number of frames; power of two; index width `IDX = log2(SETS)`.
- Tag width `TAG = 30 - IDX`. Address split: tag `[31:2+IDX]`, index `[1+IDX:2]`, byte offset `[1:0]`. The offset is ignored.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `imemREN`  in  1  datapath fetch request.
- `imemaddr`  in  32  fetch byte address.
- `imemload`  out  32  data word of the indexed frame.
- `ihit`  out  1  requested word is valid in `imemload` this cycle.
- `iREN`  out  1  memory read request.
- `iaddr`  out  32  memory word address, `{miss_addr[31:2], 2'b00}`.
- `iload`  in  32  memory read data; valid when `iwait = 0`.
- `iwait`  in  1  memory busy. 0 with `iREN = 1` means `iload` is valid this cycle.
- `hit_count`  out  32  (only with `ICACHE_STATS_EN`) completed hits.
- `miss_count`  out  32  (only with `ICACHE_STATS_EN`) refills started.

## Operation
- Each frame holds `valid` (1 bit), `tag` (TAG bits) and `data` (32 bits).
- Lookup: `hit = imemREN & valid[idx] & (tag[idx] == imemaddr tag)`.
- FSM state IDLE:
  - `ihit = hit`; `iREN = 0`.
  - If `imemREN & !hit`: latch `miss_addr = imemaddr`, go to FETCH.
- FSM state FETCH:
  - `ihit = 0`; `iREN = 1`; `iaddr` is taken from `miss_addr`, not from the live `imemaddr`.
  - On `iwait = 0`: write `data = iload`, `tag = miss_addr` tag and `valid = 1` into frame `miss_addr` index, then go to IDLE.
  - While `iwait = 1`: stay in FETCH.
- `imemload` always equals `data[imemaddr index]`; it is meaningful only when `ihit = 1`.
- A refill, once started, always completes. This holds even if `imemREN` drops or `imemaddr` changes during FETCH, because the memory transaction cannot be aborted.
- A refill into an occupied frame overwrites it; there is no write-back (read-only cache).
- No write port. Self-modifying code is unsupported.

## Timing
- Hit: combinational. `ihit` and `imemload` are valid in the same cycle as the request; zero wait states.
- Miss: cycle 0 is the IDLE miss detect (`ihit = 0`). Cycle 1 onward is FETCH with `iREN = 1`. When the fill cycle has `iwait = 0`, the next cycle is IDLE and hits on the same address.
  - Minimum miss latency is 2 cycles from request to `ihit`: one detect cycle plus one fill cycle with `iwait = 0`.
- `ihit` is never asserted in the fill cycle.
- Reset (asynchronous, including mid-FETCH):
  - All `valid` cleared, all `data` cleared to 0, state IDLE.
  - Outputs: `ihit = 0`, `iREN = 0`, `iaddr = 0`, `imemload = 0`, counters 0.
  - Any in-flight memory response after reset is ignored.
- `imemREN = 0` in IDLE: `ihit = 0`, no state change.

## Configuration
- `ICACHE_STATS_EN` defined:
  - `hit_count` increments on each cycle with `ihit = 1`.
  - `miss_count` increments on each IDLE→FETCH transition.
  - Both counters saturate at `32'hFFFF_FFFF` and clear on reset.
- `ICACHE_STATS_EN` undefined: both ports and both counters are absent. All other behaviour is identical.

## Test plan
- **Cold miss then hit:** reset, `imemREN = 1`, `imemaddr = 0x0000_0040`, memory returns `0xDEAD_BEEF` with `iwait` held 1 for 3 cycles → `iREN = 1`, `iaddr = 0x40` throughout FETCH; `ihit` rises exactly one cycle after the `iwait = 0` fill cycle, with `imemload = 0xDEAD_BEEF`.
- **Conflict eviction:** fill `0x0000_0000` (data A), then request `0x0000_0040` (same index, SETS = 16), data B → second request misses and refills; re-requesting `0x0` misses again and returns A.
- **Redirect mid-fetch:** miss on `0x100`, change `imemaddr` to `0x200` during FETCH → `iaddr` stays `0x100`; the frame for `0x100` is filled; then `0x200` misses and starts its own refill.
- **Reset mid-FETCH:** assert `nRST = 0` while `iwait = 1` → `iREN` drops to 0 immediately; after release, the earlier-filled address misses (all valid bits cleared).
- **Byte offset ignored / REN gating:** after filling `0x40`, requesting `0x43` → `ihit = 1`, same data; `imemREN = 0` with the same address → `ihit = 0` and no FSM transition.
- **Stats (`ICACHE_STATS_EN`):** 3 misses and 5 hit cycles → `miss_count = 3`, `hit_count = 5`; preload `hit_count = 0xFFFF_FFFF` via force, then one more hit → value unchanged.
